g1_input_conditioner: RTL and testbench



---
 rtl/g1_pkg.sv | 22 ++
 rtl/g1_debounce_bit.sv | 60 ++++++
 rtl/g1_input_conditioner.sv | 47 ++++
 tb/tb_g1_input_conditioner.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/g1_pkg.sv
// Shared constants and helpers for the g1 block family.
package g1_pkg;

  localparam int unsigned G1_WIDTH       = 4;
  localparam int unsigned G1_SYNC_STAGES = 2;
  localparam int unsigned G1_CNT_MAX     = 16;

  // Bits needed to hold 0..v-1; never returns less than 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned t;
    int unsigned r;
    t = v - 1;
    r = 0;
    while (t > 0) begin
      r = r + 1;
      t = t >> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/g1_debounce_bit.sv
// Single-bit synchroniser, stability counter and output flop.
// Optional busy output when G1_INPUT_BUSY_EN is defined.
module g1_debounce_bit
  import g1_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = G1_SYNC_STAGES,
  parameter int unsigned CNT_MAX     = G1_CNT_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic x,
  output logic upd_c
`ifdef G1_INPUT_BUSY_EN
  ,
  output logic busy
`endif
);

  localparam int unsigned CW = clog2(CNT_MAX);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [CW-1:0]          cnt;
  logic                   at_max;

  assign s      = sync[SYNC_STAGES-1];
  assign at_max = (cnt == CW'(CNT_MAX - 1));
  assign upd_c  = (s != x) && at_max;

  // Plain flop chain bringing sw into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], sw};
  end

  // Qualify a differing bit for CNT_MAX cycles; any agreement restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      x   <= 1'b0;
    end else if (s == x) begin
      cnt <= '0;
    end else if (at_max) begin
      x   <= s;
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

`ifdef G1_INPUT_BUSY_EN
  // Flags a bit that is part-way through qualification.
  always_ff @(posedge clk) begin
    if (rst) busy <= 1'b0;
    else     busy <= (cnt != '0);
  end
`endif

endmodule

// File: rtl/g1_input_conditioner.sv
// Synchronises and debounces the raw switch vector feeding g1_behavioral.x,
// and strobes changed for one cycle whenever the conditioned vector moves.
// Optional per-bit busy output when G1_INPUT_BUSY_EN is defined.
module g1_input_conditioner
  import g1_pkg::*;
#(
  parameter int unsigned WIDTH       = G1_WIDTH,
  parameter int unsigned SYNC_STAGES = G1_SYNC_STAGES,
  parameter int unsigned CNT_MAX     = G1_CNT_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] x,
  output logic             changed
`ifdef G1_INPUT_BUSY_EN
  ,
  output logic [WIDTH-1:0] busy
`endif
);

  logic [WIDTH-1:0] upd_c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    g1_debounce_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_MAX    (CNT_MAX)
    ) u_bit (
      .clk  (clk),
      .rst  (rst),
      .sw   (sw[i]),
      .x    (x[i]),
      .upd_c(upd_c[i])
`ifdef G1_INPUT_BUSY_EN
      ,
      .busy (busy[i])
`endif
    );
  end

  // One pulse per edge on which any bit updated, i.e. registered x != x_prev.
  always_ff @(posedge clk) begin
    if (rst) changed <= 1'b0;
    else     changed <= |upd_c;
  end

endmodule

// File: tb/tb_g1_input_conditioner.sv
// Scoreboard bench for g1_input_conditioner: stimulus pushes the expected
// (x value, edge number) of every changed pulse; a monitor pops on each pulse.
module tb_g1_input_conditioner;

  logic       clk;
  logic       rst;
  logic [3:0] sw;
  logic [3:0] x;
  logic       changed;
`ifdef G1_INPUT_BUSY_EN
  logic [3:0] busy;
`endif

  typedef struct {
    logic [3:0]  xv;
    int unsigned edge_n;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc;
  int          checks;
  int          errors;

  g1_input_conditioner dut (
    .clk    (clk),
    .rst    (rst),
    .sw     (sw),
    .x      (x),
    .changed(changed)
`ifdef G1_INPUT_BUSY_EN
    ,
    .busy   (busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int unsigned target);
    while (cyc < target) step();
  endtask

  task automatic push(input logic [3:0] xv, input int unsigned edge_n);
    exp_t e;
    e.xv     = xv;
    e.edge_n = edge_n;
    sb.push_back(e);
  endtask

  task automatic do_reset(input logic [3:0] v);
    sw  = v;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Monitor: every changed pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (changed === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_changed: x=0x%0h at edge %0d, none expected", x, cyc);
      end else begin
        e = sb.pop_front();
        chk("changed_x", 32'(x), 32'(e.xv));
        chk("changed_edge", cyc, e.edge_n);
      end
    end
  end

  initial begin
    int unsigned base;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    sw     = 4'b1111;

    // Reset held 3 cycles with sw high: outputs stay cleared.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_x", 32'(x), 0);
      chk("reset_changed", 32'(changed), 0);
    end
    rst  = 1'b0;
    base = cyc;
    push(4'b1111, base + 18);
    wait_to(base + 17);
    chk("post_reset_edge17_x", 32'(x), 0);
    wait_to(base + 25);
    chk("post_reset_x", 32'(x), 32'hF);
    chk("sb_drained_reset", sb.size(), 0);

    // Stable step from x=0 to 1011.
    do_reset(4'b0000);
    step();
    chk("step_start_x", 32'(x), 0);
    sw   = 4'b1011;
    base = cyc;
    push(4'b1011, base + 18);
    wait_to(base + 17);
    chk("step_edge17_x", 32'(x), 0);
    wait_to(base + 18);
    chk("step_edge18_x", 32'(x), 32'hB);
    wait_to(base + 30);
    chk("step_hold_x", 32'(x), 32'hB);
    chk("step_hold_changed", 32'(changed), 0);
    chk("sb_drained_step", sb.size(), 0);

    // Glitch rejection: short pulse on bit 2, then bit 0 toggling every 5 cycles.
    sw[2] = 1'b1;
    repeat (10) step();
    sw[2] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sw[0] = ~sw[0];
      repeat (5) step();
    end
    repeat (25) step();
    chk("glitch_x", 32'(x), 32'hB);
    chk("sb_drained_glitch", sb.size(), 0);

    // Independent bits: only bit 2 is continuously high from the first step.
    do_reset(4'b0000);
    step();
    sw   = 4'b0101;
    base = cyc;
    push(4'b0100, base + 18);
    push(4'b1110, base + 22);
    wait_to(base + 4);
    sw = 4'b1110;
    wait_to(base + 17);
    chk("indep_edge17_x", 32'(x), 0);
    wait_to(base + 18);
    chk("indep_edge18_x", 32'(x), 32'h4);
    wait_to(base + 21);
    chk("indep_edge21_x", 32'(x), 32'h4);
    wait_to(base + 30);
    chk("indep_final_x", 32'(x), 32'hE);
    chk("sb_drained_indep", sb.size(), 0);

    // Reset on edge 10 of a qualification discards it.
    do_reset(4'b0000);
    step();
    sw   = 4'b1000;
    base = cyc;
    wait_to(base + 9);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midreset_x", 32'(x), 0);
    base = cyc;
    push(4'b1000, base + 18);
    wait_to(base + 17);
    chk("midreset_edge17_x", 32'(x), 0);
    wait_to(base + 25);
    chk("midreset_final_x", 32'(x), 32'h8);
    chk("sb_drained_midreset", sb.size(), 0);

`ifdef G1_INPUT_BUSY_EN
    // busy tracks the stable-step qualification window.
    do_reset(4'b0000);
    step();
    sw   = 4'b1011;
    base = cyc;
    push(4'b1011, base + 18);
    wait_to(base + 3);
    chk("busy_edge3", 32'(busy), 0);
    wait_to(base + 4);
    chk("busy_edge4", 32'(busy), 32'hB);
    wait_to(base + 18);
    chk("busy_edge18", 32'(busy), 32'hB);
    wait_to(base + 19);
    chk("busy_edge19", 32'(busy), 0);
    wait_to(base + 25);
    chk("sb_drained_busy", sb.size(), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
